// File: rtl/hierarchy_seq_arbiter.sv
// hierarchy_seq_arbiter
//
// Round-robin arbiter and sequencer. It lets NREQ requesters share one
// hierarchy_seq datapath instance. It grants one requester at a time and drives
// that requester's operands onto the shared unit. The operands are held for LAT
// clocks. The captured result is then returned as a one-cycle response pulse.
//
// Ports:
//   clk        system clock, all logic on rising edge
//   rst_n      synchronous active-low reset
//   req        per-requester request level
//   req_a      per-requester operand a
//   req_b      per-requester operand b
//   gnt        one-hot grant pulse, one cycle
//   dp_a       operand a to shared hierarchy_seq
//   dp_b       operand b to shared hierarchy_seq
//   dp_c       result c from shared hierarchy_seq
//   rsp_valid  one-hot response pulse, one cycle
//   rsp_c      result for the requester flagged in rsp_valid
//   busy       high in every state except IDLE
//
// Every output is a register. The combinational process computes the *_nxt
// value of each register, including the outputs.

module hierarchy_seq_arbiter #(
    parameter int NREQ = 4,
    parameter int LAT  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] req_a,
    input  logic [NREQ-1:0] req_b,
    output logic [NREQ-1:0] gnt,
    output logic            dp_a,
    output logic            dp_b,
    input  logic            dp_c,
    output logic [NREQ-1:0] rsp_valid,
    output logic            rsp_c,
    output logic            busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(LAT) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   winner, winner_nxt;
    logic [IW-1:0]   ptr, ptr_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            dp_a_nxt, dp_b_nxt;
    logic [NREQ-1:0] gnt_nxt, rsp_valid_nxt;
    logic            rsp_c_nxt, busy_nxt;

    logic            rr_found;
    logic [IW-1:0]   rr_idx;
    logic [IW:0]     rr_sum;

    // Round-robin search. It scans upward from ptr and wraps NREQ-1 -> 0.
    // rr_sum has one extra bit so that ptr+i cannot overflow before the wrap.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_sum   = '0;
        for (int i = 0; i < NREQ; i++) begin
            rr_sum = {1'b0, ptr} + (IW+1)'(i);
            if (rr_sum >= (IW+1)'(NREQ)) begin
                rr_sum = rr_sum - (IW+1)'(NREQ);
            end
            if (!rr_found && req[rr_sum[IW-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = rr_sum[IW-1:0];
            end
        end
    end

    // Next-state logic and next values of the registered outputs.
    always_comb begin
        state_nxt     = state;
        winner_nxt    = winner;
        ptr_nxt       = ptr;
        cnt_nxt       = cnt;
        dp_a_nxt      = dp_a;
        dp_b_nxt      = dp_b;
        gnt_nxt       = '0;
        rsp_valid_nxt = '0;
        rsp_c_nxt     = rsp_c;

        case (state)
            S_IDLE: begin
                if (rr_found) begin
                    // The operands are sampled only here. Later changes to
                    // req_a/req_b do not reach the datapath.
                    winner_nxt      = rr_idx;
                    dp_a_nxt        = req_a[rr_idx];
                    dp_b_nxt        = req_b[rr_idx];
                    gnt_nxt[rr_idx] = 1'b1;
                    state_nxt       = S_GRANT;
                end else begin
                    dp_a_nxt = 1'b0;
                    dp_b_nxt = 1'b0;
                end
            end
            S_GRANT: begin
                ptr_nxt   = (winner == LAST_IDX) ? '0 : winner + 1'b1;
                cnt_nxt   = CW'(LAT - 1);
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // When the count reaches zero, dp_c reflects the operands
                // first driven in the GRANT cycle.
                if (cnt == '0) begin
                    rsp_c_nxt             = dp_c;
                    rsp_valid_nxt[winner] = 1'b1;
                    state_nxt             = S_RESP;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            S_RESP: begin
                dp_a_nxt  = 1'b0;
                dp_b_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

    // State and output registers. A reset during a transaction discards it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            winner    <= '0;
            ptr       <= '0;
            cnt       <= '0;
            dp_a      <= 1'b0;
            dp_b      <= 1'b0;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_c     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            winner    <= winner_nxt;
            ptr       <= ptr_nxt;
            cnt       <= cnt_nxt;
            dp_a      <= dp_a_nxt;
            dp_b      <= dp_b_nxt;
            gnt       <= gnt_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_c     <= rsp_c_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_hierarchy_seq_arbiter.sv
// Testbench for hierarchy_seq_arbiter.
// Instance dut uses LAT=2 with a datapath model c = a ^ b delayed 2 clocks.
// Instance dut1 uses LAT=1 with a datapath model c = a & b delayed 1 clock.

module tb_hierarchy_seq_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;

    logic [3:0] req, req_a, req_b, gnt, rsp_valid;
    logic       dp_a, dp_b, dp_c, rsp_c, busy;

    logic [3:0] req1, req1_a, req1_b, gnt1, rsp_valid1;
    logic       dp1_a, dp1_b, dp1_c, rsp1_c, busy1;

    logic       p1, p2, q1;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] gnt;
        logic [3:0] rv;
        logic       c;
        logic       da;
        logic       db;
        logic       busy;
    } vec_t;

    vec_t tbl[15];

    always #5 clk = ~clk;

    hierarchy_seq_arbiter #(.NREQ(4), .LAT(2)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c),
        .rsp_valid(rsp_valid), .rsp_c(rsp_c), .busy(busy)
    );

    hierarchy_seq_arbiter #(.NREQ(4), .LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .req_a(req1_a), .req_b(req1_b),
        .gnt(gnt1), .dp_a(dp1_a), .dp_b(dp1_b), .dp_c(dp1_c),
        .rsp_valid(rsp_valid1), .rsp_c(rsp1_c), .busy(busy1)
    );

    // Shared datapath models
    always @(posedge clk) begin
        p1 <= dp_a ^ dp_b;
        p2 <= p1;
        q1 <= dp1_a & dp1_b;
    end
    assign dp_c  = p2;
    assign dp1_c = q1;

    // Every cycle outside reset: gnt and rsp_valid are one-hot-or-zero and never coincide
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            compared++;
            if ((gnt != 4'b0 && rsp_valid != 4'b0) || !$onehot0(gnt) || !$onehot0(rsp_valid) ||
                (gnt1 != 4'b0 && rsp_valid1 != 4'b0) || !$onehot0(gnt1) || !$onehot0(rsp_valid1)) begin
                mismatched++;
                $display("[TB] FAIL onehot_excl: gnt=%b rsp_valid=%b gnt1=%b rsp_valid1=%b required exclusive one-hot",
                         gnt, rsp_valid, gnt1, rsp_valid1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    task automatic checkCount(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        req   = v.req;
        req_a = v.a;
        req_b = v.b;
        step();
        checkOutput("tbl_gnt", gnt, v.gnt);
        checkOutput("tbl_rsp_valid", rsp_valid, v.rv);
        checkOutput("tbl_dp_a", {3'b0, dp_a}, {3'b0, v.da});
        checkOutput("tbl_dp_b", {3'b0, dp_b}, {3'b0, v.db});
        checkOutput("tbl_busy", {3'b0, busy}, {3'b0, v.busy});
        if (v.rv != 4'b0) begin
            checkOutput("tbl_rsp_c", {3'b0, rsp_c}, {3'b0, v.c});
        end
    endtask

    // Waits for the next grant on dut and returns the number of steps taken (bounded)
    task automatic waitGnt(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (gnt == 4'b0 && n < 20);
    endtask

    task automatic waitGnt1(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (gnt1 == 4'b0 && n < 20);
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 20) begin
            step();
            n++;
        end
        checkOutput("wait_idle", {3'b0, busy}, 4'b0);
    endtask

    initial begin
        logic [3:0] fair_exp[5];
        logic [3:0] fair1_exp[4];
        int n;

        fair_exp  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        fair1_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Inputs apply during the row's cycle. Expected values apply to the following cycle.
        // Lane 2 alone with a=1,b=0 from ptr=1: c=1
        tbl[0]  = '{4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[1]  = '{4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[3]  = '{4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[4]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};
        // Lanes 0,1 from ptr=3 wrap to lane 0 (a=0,b=1): c=1
        tbl[5]  = '{4'b0011, 4'b0010, 4'b0011, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[6]  = '{4'b0000, 4'b0010, 4'b0011, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[7]  = '{4'b0000, 4'b0010, 4'b0011, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[8]  = '{4'b0000, 4'b0010, 4'b0011, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[9]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};
        // Lanes 0,3 from ptr=1 pick lane 3 (a=1,b=1): c=0
        tbl[10] = '{4'b1001, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[11] = '{4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[12] = '{4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[13] = '{4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b1000, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[14] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        req = 4'b1111; req_a = 4'b0; req_b = 4'b0;
        req1 = 4'b0; req1_a = 4'b0; req1_b = 4'b0;

        // Reset held for 3 cycles with every request up
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("rst_gnt", gnt, 4'b0);
            checkOutput("rst_rsp_valid", rsp_valid, 4'b0);
            checkOutput("rst_dp", {2'b0, dp_a, dp_b}, 4'b0);
            checkOutput("rst_busy", {3'b0, busy}, 4'b0);
        end
        rst_n = 1'b1;
        step();
        checkOutput("first_gnt", gnt, 4'b0001);
        req = 4'b0;
        step(); step(); step();
        checkOutput("first_rsp", rsp_valid, 4'b0001);
        step();
        checkOutput("first_idle", {3'b0, busy}, 4'b0);

        for (int i = 0; i < 15; i++) begin
            applyStimulus(tbl[i]);
        end

        // Fairness under constant requests, from ptr=0
        req = 4'b1111; req_a = 4'b0; req_b = 4'b0;
        for (int k = 0; k < 5; k++) begin
            waitGnt(n);
            checkOutput("fair_gnt", gnt, fair_exp[k]);
            if (k > 0) checkCount("fair_spacing", n, 5);
        end
        req = 4'b0;
        waitIdle();

        // Operand isolation on lane 1 (a=1,b=0), from ptr=1
        req = 4'b0010; req_a = 4'b0010; req_b = 4'b0000;
        step();
        checkOutput("iso_gnt", gnt, 4'b0010);
        req = 4'b0000; req_a = 4'b0000; req_b = 4'b0010;
        step();
        checkOutput("iso_dp_w1", {2'b0, dp_a, dp_b}, 4'b0010);
        req_a = 4'b1111; req_b = 4'b1111;
        step();
        checkOutput("iso_dp_w2", {2'b0, dp_a, dp_b}, 4'b0010);
        step();
        checkOutput("iso_rsp_valid", rsp_valid, 4'b0010);
        checkOutput("iso_rsp_c", {3'b0, rsp_c}, 4'b0001);
        req_a = 4'b0; req_b = 4'b0;
        step();
        checkOutput("iso_idle", {3'b0, busy}, 4'b0);

        // Reset during WAIT; lane 2 wins from ptr=2, then ptr would be 3
        req = 4'b1100;
        step();
        checkOutput("rmid_gnt", gnt, 4'b0100);
        step();
        step();
        rst_n = 1'b0;
        step();
        checkOutput("rmid_rsp_valid", rsp_valid, 4'b0);
        checkOutput("rmid_busy", {3'b0, busy}, 4'b0);
        step();
        checkOutput("rmid_rsp_valid2", rsp_valid, 4'b0);
        rst_n = 1'b1;
        step();
        checkOutput("rmid_next_gnt", gnt, 4'b0100);
        req = 4'b0;
        waitIdle();

        // LAT=1 instance: lane 0, a=1,b=1, model a&b -> 1
        req1 = 4'b0001; req1_a = 4'b0001; req1_b = 4'b0001;
        step();
        checkOutput("l1_gnt", gnt1, 4'b0001);
        req1 = 4'b0;
        step();
        checkOutput("l1_rsp_early", rsp_valid1, 4'b0);
        checkOutput("l1_busy", {3'b0, busy1}, 4'b0001);
        step();
        checkOutput("l1_rsp_valid", rsp_valid1, 4'b0001);
        checkOutput("l1_rsp_c", {3'b0, rsp1_c}, 4'b0001);
        req1_a = 4'b0; req1_b = 4'b0;
        step();
        checkOutput("l1_idle", {3'b0, busy1}, 4'b0);

        req1 = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            waitGnt1(n);
            checkOutput("l1_fair_gnt", gnt1, fair1_exp[k]);
            if (k > 0) checkCount("l1_spacing", n, 4);
        end
        req1 = 4'b0;
        step(); step(); step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/hierarchy_seq_arbiter.md
Name: hierarchy_seq_arbiter

Overview:
Round-robin arbiter and sequencer that lets NREQ requesters share a single hierarchy_seq datapath instance (1-bit operands a, b; 1-bit result c, valid LAT clocks after the operands are presented).
It grants one requester at a time and drives that requester's operands onto the shared unit.
It holds the operands stable for the datapath latency, then returns the captured result to the granted requester as a one-cycle response pulse.
It sits between the requester-side test logic and the hierarchy_seq instance.

Parameters:
NREQ, 4, number of requesters (2..8)
LAT, 2, clocks from dp_a/dp_b first presented to dp_c valid (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
req  input  NREQ  per-requester request level
req_a  input  NREQ  per-requester operand a
req_b  input  NREQ  per-requester operand b
gnt  output  NREQ  one-hot grant pulse, one cycle
dp_a  output  1  operand a to shared hierarchy_seq
dp_b  output  1  operand b to shared hierarchy_seq
dp_c  input  1  result c from shared hierarchy_seq
rsp_valid  output  NREQ  one-hot response pulse, one cycle
rsp_c  output  1  result for the requester flagged in rsp_valid
busy  output  1  high in every state except IDLE

Behaviour:
- The block has one clock (clk). Reset is synchronous and active-low (rst_n).
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; gnt, rsp_valid, rsp_c, dp_a, dp_b, busy all 0.
  - RR pointer=0; wait counter=0.
  - Reset asserted mid-transaction aborts it. No rsp_valid is issued, and the result is discarded.
- All outputs are registered.
- FSM states: IDLE -> GRANT -> WAIT -> RESP -> IDLE.
- IDLE:
  - Sample req each cycle. If any bit is set, select the winner by round-robin starting at the pointer index, scanning upward with wrap NREQ-1 -> 0.
  - Next state is GRANT. Latch the winner index; dp_a/dp_b <= req_a/req_b of the winner.
  - If no request, stay in IDLE with dp_a=dp_b=0.
- GRANT (1 cycle):
  - gnt[winner]=1. dp_a/dp_b hold the latched operands.
  - Pointer <= (winner+1) mod NREQ. Counter <= LAT-1. Next state is WAIT.
- WAIT:
  - dp_a/dp_b held stable. Counter decrements each cycle.
  - When the counter is 0, capture dp_c into rsp_c at that edge and go to RESP.
  - WAIT lasts LAT cycles (for LAT=1, one cycle).
- RESP (1 cycle):
  - rsp_valid[winner]=1 and rsp_c is valid. Next state is IDLE; dp_a/dp_b <= 0 on exit.
- Timing: if gnt is high in cycle g, rsp_valid is high in cycle g+LAT+1. The next gnt is earliest at g+LAT+3. Throughput is 1 transaction per LAT+3 cycles.
- Request rules:
  - Requesters are not latched. A req deasserted while in IDLE before the grant is simply not seen.
  - Operands are sampled only in the IDLE cycle that selects the winner. Later changes on req_a/req_b are ignored.
  - req dropping after the grant does not cancel the transaction.
  - req held high through RESP is treated as a new request in the next IDLE cycle, subject to round-robin.
- Simultaneous requests: exactly one grant per transaction. The winner becomes lowest priority next round. No requester waits more than NREQ-1 transactions.
- The winner index is stored in $clog2(NREQ) bits (minimum 1). The counter is $clog2(LAT)+1 bits wide.
- gnt and rsp_valid are never high in the same cycle. At most one bit of each is set.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with all req=1 -> gnt=0, rsp_valid=0, dp_a=dp_b=0, busy=0. After release, first gnt=4'b0001.
- Single requester: NREQ=4, LAT=2, req=4'b0100, req_a=1, req_b=0 in that lane, bench datapath model c=a^b delayed 2 clocks.
  - Required: gnt=4'b0100 at cycle g; dp_a=1, dp_b=0 stable from g-0 through g+2.
  - Required: rsp_valid=4'b0100 with rsp_c=1 at g+3; busy low at g+4.
- Fairness: req=4'b1111 held constantly -> grants in the order 0001, 0010, 0100, 1000, 0001, spaced 5 cycles apart.
- Operand isolation: toggle the granted requester's req_a/req_b and drop its req during WAIT -> dp_a/dp_b unchanged and the response still delivered with the original-operand result.
- Reset mid-operation: assert rst_n=0 during WAIT -> no rsp_valid ever appears for that transaction; pointer=0, so the next grant goes to the lowest active index.
- LAT=1 build: single request with a=1, b=1 -> rsp_valid at g+2 with rsp_c = model(1,1); gnt spacing under constant requests is 4 cycles.
